apple2_io_responder: RTL and testbench

// - Bus responder for the CPU-side memory interface: serves the Apple II I/O page $C000-$C0FF.
//   - Keyboard latch/strobe, fed from a small key FIFO.
//   - Speaker toggle.
//   - Video soft switches.
// - Read data is registered and returned one cycle after the address, the same timing as the sync ROMs.
//   The top-level data mux selects io_data_out whenever io_cs_r=1.

---
 rtl/apple2_io_responder.sv | 159 +++++++++++++++
 tb/tb_apple2_io_responder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/apple2_io_responder.sv
// Apple II I/O page ($C000-$C0FF) responder: keyboard latch/strobe fed by a key FIFO,
// speaker toggle and video soft switches. Read data is registered (latency 1).
module apple2_io_responder #(
   parameter int KBD_FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] cpu_addr,
   input  logic        cpu_we,
   input  logic [7:0]  cpu_data_in,
   output logic [7:0]  io_data_out,
   output logic        io_cs_r,
   input  logic        kbd_valid,
   input  logic [6:0]  kbd_ascii,
   output logic        kbd_ready,
   output logic        sw_text,
   output logic        sw_mixed,
   output logic        sw_page2,
   output logic        sw_hires,
   output logic        speaker
);

   localparam int AW = $clog2(KBD_FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic        sel_s, kbd_rd_s, clr_s, spk_s, sw_s;
   logic        full_s, empty_s, push_s, pop_s;
   logic        unused_s;

   logic [7:0]  data_q, data_d;
   logic        cs_q, cs_d;
   logic        spk_q, spk_d;
   logic        text_q, text_d;
   logic        mixed_q, mixed_d;
   logic        page2_q, page2_d;
   logic        hires_q, hires_d;
   logic        strobe_q, strobe_d;
   logic [6:0]  latch_q, latch_d;
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic [6:0]  mem_q [KBD_FIFO_DEPTH];
   logic [6:0]  mem_d [KBD_FIFO_DEPTH];

   // Writes behave exactly like reads on the I/O page, so write data is never used.
   assign unused_s = ^{cpu_we, cpu_data_in};

   assign sel_s    = (cpu_addr[15:8] == 8'hC0);
   assign kbd_rd_s = sel_s && (cpu_addr[7:5] == 3'b000);
   assign clr_s    = sel_s && (cpu_addr[7:4] == 4'h1);
   assign spk_s    = sel_s && (cpu_addr[7:4] == 4'h3);
   assign sw_s     = sel_s && (cpu_addr[7:3] == 5'b01010);

   assign empty_s  = (wr_ptr_q == rd_ptr_q);
   assign full_s   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign push_s   = kbd_valid && !full_s;
   // A $C01x access blocks the pop so a clear is always visible for one cycle.
   assign pop_s    = !empty_s && !strobe_q && !clr_s;

   // Next-state for read path, side effects and key FIFO.
   always_comb begin
      data_d   = 8'h00;
      cs_d     = sel_s;
      spk_d    = spk_q;
      text_d   = text_q;
      mixed_d  = mixed_q;
      page2_d  = page2_q;
      hires_d  = hires_q;
      strobe_d = strobe_q;
      latch_d  = latch_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;

      if (kbd_rd_s) begin
         data_d = {strobe_q, latch_q};
      end else begin
         data_d = 8'h00;
      end

      if (spk_s) begin
         spk_d = ~spk_q;
      end else begin
         spk_d = spk_q;
      end

      if (sw_s) begin
         case (cpu_addr[2:1])
            2'd0:    text_d  = cpu_addr[0];
            2'd1:    mixed_d = cpu_addr[0];
            2'd2:    page2_d = cpu_addr[0];
            2'd3:    hires_d = cpu_addr[0];
            default: text_d  = text_q;
         endcase
      end else begin
         text_d = text_q;
      end

      if (push_s) begin
         mem_d[wr_ptr_q[AW-1:0]] = kbd_ascii;
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (clr_s) begin
         strobe_d = 1'b0;
      end else if (pop_s) begin
         strobe_d = 1'b1;
         latch_d  = mem_q[rd_ptr_q[AW-1:0]];
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         strobe_d = strobe_q;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q   <= 8'h00;
         cs_q     <= 1'b0;
         spk_q    <= 1'b0;
         text_q   <= 1'b1;
         mixed_q  <= 1'b0;
         page2_q  <= 1'b0;
         hires_q  <= 1'b0;
         strobe_q <= 1'b0;
         latch_q  <= 7'h00;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < KBD_FIFO_DEPTH; i++) begin
            mem_q[i] <= 7'h00;
         end
      end else begin
         data_q   <= data_d;
         cs_q     <= cs_d;
         spk_q    <= spk_d;
         text_q   <= text_d;
         mixed_q  <= mixed_d;
         page2_q  <= page2_d;
         hires_q  <= hires_d;
         strobe_q <= strobe_d;
         latch_q  <= latch_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end

   assign io_data_out = data_q;
   assign io_cs_r     = cs_q;
   assign kbd_ready   = !full_s;
   assign sw_text     = text_q;
   assign sw_mixed    = mixed_q;
   assign sw_page2    = page2_q;
   assign sw_hires    = hires_q;
   assign speaker     = spk_q;

endmodule

// File: tb/tb_apple2_io_responder.sv
// Directed testbench for apple2_io_responder: reset, key path, FIFO full, clear/pop
// collision, soft switches, speaker and mid-operation reset.
module tb_apple2_io_responder;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] cpu_addr = 16'h0000;
   logic        cpu_we = 1'b0;
   logic [7:0]  cpu_data_in = 8'h00;
   logic        kbd_valid = 1'b0;
   logic [6:0]  kbd_ascii = 7'h00;
   logic [7:0]  io_data_out;
   logic        io_cs_r, kbd_ready;
   logic        sw_text, sw_mixed, sw_page2, sw_hires, speaker;

   int          err_cnt = 0;
   int          chk_cnt = 0;
   int          acc_cnt = 0;
   logic        pre_ok = 1'b0;
   logic [6:0]  key_q[$];

   apple2_io_responder #(.KBD_FIFO_DEPTH(4)) dut (
      .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_we(cpu_we),
      .cpu_data_in(cpu_data_in), .io_data_out(io_data_out), .io_cs_r(io_cs_r),
      .kbd_valid(kbd_valid), .kbd_ascii(kbd_ascii), .kbd_ready(kbd_ready),
      .sw_text(sw_text), .sw_mixed(sw_mixed), .sw_page2(sw_page2),
      .sw_hires(sw_hires), .speaker(speaker)
   );

   always #5 clk = ~clk;

   // Key source: offers the queue head and holds it until the responder accepts it.
   always @(negedge clk) pre_ok = reset_n && kbd_valid && kbd_ready;
   always @(posedge clk) begin
      if (pre_ok && key_q.size() > 0) begin
         void'(key_q.pop_front());
         acc_cnt++;
      end
      #2;
      if (key_q.size() > 0) begin
         kbd_valid = 1'b1;
         kbd_ascii = key_q[0];
      end else begin
         kbd_valid = 1'b0;
         kbd_ascii = 7'h00;
      end
   end

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic step(input logic [15:0] a, input logic we);
      cpu_addr    = a;
      cpu_we      = we;
      cpu_data_in = we ? 8'hFF : 8'h00;
      @(posedge clk);
      #1;
      cpu_addr    = 16'h0000;
      cpu_we      = 1'b0;
      cpu_data_in = 8'h00;
   endtask

   task automatic chk_reset_state(input string tag);
      chk_eq({tag, "_data"},  32'(io_data_out), 32'h00);
      chk_eq({tag, "_cs"},    32'(io_cs_r),     32'h0);
      chk_eq({tag, "_spk"},   32'(speaker),     32'h0);
      chk_eq({tag, "_text"},  32'(sw_text),     32'h1);
      chk_eq({tag, "_mixed"}, 32'(sw_mixed),    32'h0);
      chk_eq({tag, "_page2"}, 32'(sw_page2),    32'h0);
      chk_eq({tag, "_hires"}, 32'(sw_hires),    32'h0);
      chk_eq({tag, "_ready"}, 32'(kbd_ready),   32'h1);
   endtask

   initial begin
      // Traffic while held in reset: a pending key and switch/speaker accesses.
      key_q.push_back(7'h55);
      cpu_addr = 16'hC050;
      idle(1);
      cpu_addr = 16'hC030;
      idle(1);
      cpu_addr = 16'hC057;
      idle(1);
      chk_reset_state("rst");
      key_q.delete();
      cpu_addr = 16'h0000;
      idle(1);
      reset_n = 1'b1;
      idle(1);
      step(16'hC000, 1'b0);
      chk_eq("rst_first_rd", 32'(io_data_out), 32'h00);
      chk_eq("rst_first_cs", 32'(io_cs_r), 32'h1);

      // Key path
      key_q.push_back(7'h41);
      idle(3);
      chk_eq("key_acc", 32'(acc_cnt), 32'd1);
      step(16'hC000, 1'b0);
      chk_eq("key_strobe_rd", 32'(io_data_out), 32'hC1);
      step(16'hC010, 1'b0);
      chk_eq("key_clr_rd", 32'(io_data_out), 32'hC1);
      step(16'hC000, 1'b0);
      chk_eq("key_after_clr", 32'(io_data_out), 32'h41);

      // FIFO full: 6 keys offered, 5 accepted
      for (int i = 0; i < 6; i++) key_q.push_back(7'h31 + 7'(i));
      idle(10);
      chk_eq("full_acc", 32'(acc_cnt), 32'd6);
      chk_eq("full_ready", 32'(kbd_ready), 32'h0);
      chk_eq("full_valid", 32'(kbd_valid), 32'h1);
      for (int i = 0; i < 6; i++) begin
         step(16'hC000, 1'b0);
         chk_eq($sformatf("full_rd%0d", i), 32'(io_data_out), 32'hB1 + 32'(i));
         step(16'hC010, 1'b0);
         idle(1);
      end
      step(16'hC000, 1'b0);
      chk_eq("full_last", 32'(io_data_out), 32'h36);
      chk_eq("full_acc_end", 32'(acc_cnt), 32'd7);
      chk_eq("full_ready_end", 32'(kbd_ready), 32'h1);

      // Clear/pop collision
      key_q.push_back(7'h50);
      key_q.push_back(7'h42);
      idle(5);
      step(16'hC010, 1'b0);
      chk_eq("col_clr", 32'(io_data_out), 32'hD0);
      step(16'hC000, 1'b0);
      chk_eq("col_gap", 32'(io_data_out), 32'h50);
      step(16'hC000, 1'b0);
      chk_eq("col_pop", 32'(io_data_out), 32'hC2);

      // Keyboard range boundaries
      step(16'hC01F, 1'b0);
      chk_eq("kbd_c01f", 32'(io_data_out), 32'hC2);
      step(16'hC00F, 1'b0);
      chk_eq("kbd_c00f", 32'(io_data_out), 32'h42);
      step(16'hC020, 1'b0);
      chk_eq("kbd_c020", 32'(io_data_out), 32'h00);

      // Soft switches
      step(16'hC050, 1'b0);
      chk_eq("sw50_text", 32'(sw_text), 32'h0);
      chk_eq("sw50_data", 32'(io_data_out), 32'h00);
      chk_eq("sw50_cs", 32'(io_cs_r), 32'h1);
      step(16'hC053, 1'b0);
      chk_eq("sw53_mixed", 32'(sw_mixed), 32'h1);
      chk_eq("sw53_data", 32'(io_data_out), 32'h00);
      step(16'hC055, 1'b1);
      chk_eq("sw55_page2", 32'(sw_page2), 32'h1);
      chk_eq("sw55_cs", 32'(io_cs_r), 32'h1);
      step(16'hC057, 1'b0);
      chk_eq("sw57_hires", 32'(sw_hires), 32'h1);
      chk_eq("sw57_text", 32'(sw_text), 32'h0);
      step(16'hC051, 1'b0);
      chk_eq("sw51_text", 32'(sw_text), 32'h1);
      chk_eq("sw51_mixed", 32'(sw_mixed), 32'h1);

      // Speaker
      chk_eq("spk_init", 32'(speaker), 32'h0);
      step(16'hC030, 1'b0);
      chk_eq("spk_t1", 32'(speaker), 32'h1);
      idle(1);
      step(16'hC030, 1'b1);
      chk_eq("spk_t2", 32'(speaker), 32'h0);
      idle(1);
      step(16'hC030, 1'b0);
      chk_eq("spk_t3", 32'(speaker), 32'h1);
      step(16'hC040, 1'b0);
      chk_eq("spk_c040", 32'(speaker), 32'h1);
      chk_eq("c040_data", 32'(io_data_out), 32'h00);

      // Outside the I/O page
      step(16'h1234, 1'b0);
      chk_eq("nosel_cs", 32'(io_cs_r), 32'h0);
      chk_eq("nosel_data", 32'(io_data_out), 32'h00);
      step(16'hC130, 1'b0);
      chk_eq("c130_cs", 32'(io_cs_r), 32'h0);
      chk_eq("c130_spk", 32'(speaker), 32'h1);

      // Reset during key traffic
      key_q.push_back(7'h60);
      key_q.push_back(7'h61);
      key_q.push_back(7'h62);
      cpu_addr = 16'hC050;
      idle(2);
      reset_n = 1'b0;
      #1;
      chk_reset_state("mid_rst");
      key_q.delete();
      cpu_addr = 16'h0000;
      idle(2);
      reset_n = 1'b1;
      idle(3);
      step(16'hC000, 1'b0);
      chk_eq("mid_rst_rd", 32'(io_data_out), 32'h00);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
